// File: rtl/zuc_f_unit.sv
// ZUC nonlinear function F shared by NCH time-interleaved channels, two-stage registered.
// Optional state readback ports are enabled by defining ZUC_F_STATE_RB_EN.
module zuc_f_unit #(
    parameter int NCH = 4,
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [1:0]     in_op,
    input  logic [CHW-1:0] in_ch,
    input  logic [31:0]    in_x0,
    input  logic [31:0]    in_x1,
    input  logic [31:0]    in_x2,
    output logic           out_valid,
    output logic [CHW-1:0] out_ch,
    output logic [31:0]    w_out
`ifdef ZUC_F_STATE_RB_EN
    ,
    input  logic [CHW-1:0] rb_ch,
    output logic [31:0]    rb_r1,
    output logic [31:0]    rb_r2
`endif
);

    localparam logic [1:0] OP_STEP  = 2'b00;
    localparam logic [1:0] OP_INIT  = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_NOP   = 2'b11;
    localparam logic [CHW:0] NCH_W  = (CHW + 1)'(NCH);

    // Byte 0 of each table sits in the most significant byte.
    localparam logic [2047:0] S0_TAB = {
        128'h3e725b47cae0003304d1549809b96dcb, 128'h7b1bf932af9d6aa5b82dfc1d08530390,
        128'h4d4e8499e4ced991ddb685488b296eac, 128'hcdc1f81e734369c6b5bdfd396320d438,
        128'h767db2a7cfed57c5f32cbb142106559b, 128'he3ef5e314f7f5aa40d8251495fba581c,
        128'h4a16d517a892241f8cffd8ae2e01d3ad, 128'h3b4bda46ebc9de9a8f87d73a806f2fc8,
        128'hb1b437f70a2213287ccc3c89c7c39656, 128'h07bf7ef00b2b975235417961a64c10fe,
        128'hbc2695888ab0a3fbc01894f2e1e5e95d, 128'hd0dc1166645cec59427512f5749caa23,
        128'h0e86abbe2a02e767e644a26cc2939ff1, 128'hf6fa36d250689e6271153dd640c4e20f,
        128'h8e83776b25053f0c30ea70b7a1e8a965, 128'h8d271adb81b3a0f4457a19dfee783460};
    localparam logic [2047:0] S1_TAB = {
        128'h55c263713bc847869f3cda5b29aafd77, 128'h8cc5940ca61a1300e3a8167240f9f842,
        128'h4426689681d9453e1076c6a78b3943e1, 128'h3ab5562ac06db3052266bfdc0bfa6248,
        128'hdd20110636c9c1cff62752bb69f5d487, 128'h7f844cd29c57a4bc4f9adffed68d7aeb,
        128'h2b53d85ca11417fb23d57d3067730809, 128'heeb7703f61b2198e4ee54b938f5ddba9,
        128'hadf1ae2ecb0dfcf42d466e1d97e8d1e9, 128'h4d37a5755e839eab829db91ce0cd4989,
        128'h01b6bd5824a25f387899159050b895e4, 128'hd091c7ceed0fb46fa0ccf0024a79c3de,
        128'ha3efea51e66b18ec1b2c80f774e7ff21, 128'h5a6a541e41319235c433070aba7e0e34,
        128'h88b1987cf33d606c7bcad31f32650428, 128'h64be859b2f598ad7b025acaf1203e2f2};

    function automatic logic [7:0] sbox0(input logic [7:0] a);
        return S0_TAB[(255 - int'(a)) * 8 +: 8];
    endfunction

    function automatic logic [7:0] sbox1(input logic [7:0] a);
        return S1_TAB[(255 - int'(a)) * 8 +: 8];
    endfunction

    function automatic logic [31:0] sbox32(input logic [31:0] x);
        return {sbox0(x[31:24]), sbox1(x[23:16]), sbox0(x[15:8]), sbox1(x[7:0])};
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    logic [31:0]    r1_q [NCH];
    logic [31:0]    r2_q [NCH];
    logic           s1_valid_q;
    logic [1:0]     s1_op_q;
    logic [CHW-1:0] s1_ch_q;
    logic [31:0]    s1_w1_q, s1_w2_q;
    logic           out_valid_q;
    logic [CHW-1:0] out_ch_q;
    logic [31:0]    w_out_q;

    logic           in_ch_ok, s1_ch_ok, accept, fire_d, s1_wr;
    logic [31:0]    r1_rd, r2_rd, w_d, w1_d, w2_d, u, v, r1_d, r2_d;

    // A same-channel request must wait until the pending stage-2 write lands.
    assign in_ready = !(s1_valid_q && (s1_op_q != OP_NOP) && (in_ch == s1_ch_q));
    assign accept   = in_valid && in_ready;

    always_comb begin
        in_ch_ok = ({1'b0, in_ch} < NCH_W);
        s1_ch_ok = ({1'b0, s1_ch_q} < NCH_W);
        r1_rd    = '0;
        r2_rd    = '0;
        if (in_ch_ok) begin
            r1_rd = r1_q[in_ch];
            r2_rd = r2_q[in_ch];
        end
        w_d    = (in_x0 ^ r1_rd) + r2_rd;
        w1_d   = r1_rd + in_x1;
        w2_d   = r2_rd ^ in_x2;
        fire_d = accept && in_ch_ok && ((in_op == OP_STEP) || (in_op == OP_INIT));
        s1_wr  = s1_valid_q && (s1_op_q != OP_NOP) && s1_ch_ok;
        u      = {s1_w1_q[15:0], s1_w2_q[31:16]};
        v      = {s1_w2_q[15:0], s1_w1_q[31:16]};
        r1_d   = sbox32(u ^ rotl(u, 2) ^ rotl(u, 10) ^ rotl(u, 18) ^ rotl(u, 24));
        r2_d   = sbox32(v ^ rotl(v, 8) ^ rotl(v, 14) ^ rotl(v, 22) ^ rotl(v, 30));
        if (s1_op_q == OP_CLEAR) begin
            r1_d = '0;
            r2_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= OP_NOP;
            s1_ch_q     <= '0;
            s1_w1_q     <= '0;
            s1_w2_q     <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            w_out_q     <= '0;
            for (int i = 0; i < NCH; i++) begin
                r1_q[i] <= '0;
                r2_q[i] <= '0;
            end
        end else begin
            s1_valid_q  <= accept;
            out_valid_q <= fire_d;
            if (accept) begin
                s1_op_q <= in_op;
                s1_ch_q <= in_ch;
                s1_w1_q <= w1_d;
                s1_w2_q <= w2_d;
            end
            if (fire_d) begin
                out_ch_q <= in_ch;
                w_out_q  <= (in_op == OP_INIT) ? {1'b0, w_d[31:1]} : w_d;
            end
            if (s1_wr) begin
                r1_q[s1_ch_q] <= r1_d;
                r2_q[s1_ch_q] <= r2_d;
            end
        end
    end

    // A reset landing right after an accept suppresses that pulse.
    assign out_valid = out_valid_q && rst_n;
    assign out_ch    = out_ch_q;
    assign w_out     = w_out_q;

`ifdef ZUC_F_STATE_RB_EN
    always_comb begin
        rb_r1 = '0;
        rb_r2 = '0;
        if ({1'b0, rb_ch} < NCH_W) begin
            rb_r1 = r1_q[rb_ch];
            rb_r2 = r2_q[rb_ch];
        end
    end
`endif

endmodule

// File: doc/zuc_f_unit.md
# zuc_f_unit

Multi-channel, registered ZUC nonlinear function F with per-channel R1/R2 state held internally. It sits between the per-channel LFSR/bit-reorganisation logic and the keystream XOR. It serves NCH time-interleaved ZUC instances from one datapath, supports initialisation and working modes plus a per-channel state clear, and resolves same-channel read-after-write hazards with a valid/ready stall.

## Interface
- NCH, 4: number of independent channels (≥1); CHW = max(1, clog2(NCH))
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous reset, active low
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- in_op  in  2  00 STEP, 01 INIT, 10 CLEAR, 11 NOP
- in_ch  in  CHW  target channel
- in_x0, in_x1, in_x2  in  32 each  BR outputs X0, X1, X2
- out_valid  out  1  one-cycle pulse, w_out valid
- out_ch  out  CHW  channel of w_out
- w_out  out  32  W (STEP) or W>>1 (INIT)

## Operation
- State: R1[NCH], R2[NCH], 32 b each. Reset value is 0.
- Stage 1 (on accept): read R1/R2[in_ch] and compute. All additions are mod 2^32 and any carry out is discarded.
  - W = (X0 ^ R1) + R2
  - W1 = R1 + X1
  - W2 = R2 ^ X2
  - Register s1_valid, s1_op, s1_ch, W, W1, W2.
- w_out: STEP gives W. INIT gives {1'b0, W[31:1]}.
- Stage 2 (cycle after stage 1):
  - Form U = W1[15:0] || W2[31:16] and V = W2[15:0] || W1[31:16].
  - L1(U) = U ^ (U<<<2) ^ (U<<<10) ^ (U<<<18) ^ (U<<<24).
  - L2(V) = V ^ (V<<<8) ^ (V<<<14) ^ (V<<<22) ^ (V<<<30).
  - R1[ch] ← S(L1) and R2[ch] ← S(L2). S applies S0, S1, S0, S1 to bytes MSB first, using the existing byte S-box modules.
- CLEAR: takes the stage path and writes R1 = R2 = 0 at stage 2. It produces no out_valid.
- NOP: accepted and has no effect.
- An in_ch ≥ NCH is accepted and treated as NOP: no state write, no out_valid.
- Hazard rule: in_ready = 0 iff s1_valid and s1_op ∈ {STEP, INIT, CLEAR} and in_ch == s1_ch. Otherwise in_ready = 1.
- There is no output backpressure. The consumer must take w_out in the out_valid cycle.

## Timing
- Reset values: in_ready 1, out_valid 0, out_ch 0, w_out 0, s1_valid 0, all R1/R2 0.
- Request accepted at edge t: out_valid, out_ch and w_out are registered outputs, asserted during cycle t+1 (latency 1).
- The R1/R2 write for that request happens at edge t+1.
- Same-channel throughput is one op per 2 cycles, because the request is stalled for exactly one cycle.
- Different-channel throughput is one op per cycle.
- A stage-2 write and a new accept in the same cycle for different channels both take effect.
- Reset asserted mid-operation: the pending stage-1 op is dropped, no out_valid is produced, and all state returns to 0.
- in_ready is combinational from in_ch, s1_valid, s1_op and s1_ch only. It does not depend on in_valid.

## Configuration
- Macro: ZUC_F_STATE_RB_EN.
- Defined: adds state readback ports.
  - rb_ch  in  CHW
  - rb_r1  out  32, combinational R1[rb_ch]
  - rb_r2  out  32, combinational R2[rb_ch]
  - An rb_ch ≥ NCH reads 0.
  - Readback shows the value before any same-edge stage-2 write.
- Undefined: these ports and their logic are absent. All other behaviour is identical.

## Test plan
- Reset, then CLEAR ch0, then STEP ch0 with X0=0x12345678, X1=X2=0. Expect out_valid one cycle later, w_out=0x12345678, out_ch=0. R1 and R2 become 0x3E553E55.
- INIT ch1 from reset with X0=0x12345678, X1=X2=0. Expect w_out=0x091A2B3C.
- Follow-up on ch0: STEP with X0=0x3E553E55, X1=X2=0, after ch0's state has updated. Expect w_out=0x3E553E55.
- Hazard: STEP ch2 at cycle t, then request ch2 at t+1. Expect in_ready=0 at t+1 and acceptance at t+2.
- Interleave: ch0 and ch1 on consecutive cycles with no stall. Expect matching out_ch per pulse.
- With NCH=4:
  - in_ch=5 (only if CHW allows, e.g. NCH=5 built with in_ch=7) is accepted, gives no out_valid and leaves state unchanged.
  - rst_n low in the cycle after an accept gives no out_valid, and rb_r1/rb_r2=0 when ZUC_F_STATE_RB_EN is defined.
